// File: rtl/bp_pkg.sv
// Shared encodings for the branch pattern history table: 2-bit counter states,
// resolved-direction actions, sweep init value and the table controller state.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic ACT_NT = 1'b0;
    localparam logic ACT_T  = 1'b1;

    localparam logic [1:0] INIT_VAL = WNT;

    typedef enum logic {
        INIT,
        RUN
    } pht_state_e;

endpackage

// File: rtl/branch_pht_counter2.sv
// counter2: combinational next-state function of a 2-bit saturating branch
// counter, moving one step toward ST on taken and toward SNT on not-taken.
module counter2
    import bp_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       taken_i,
    output logic [1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        case (cnt_i)
            SNT:     cnt_o = (taken_i == ACT_T) ? WNT : SNT;
            WNT:     cnt_o = (taken_i == ACT_T) ? WT  : SNT;
            WT:      cnt_o = (taken_i == ACT_T) ? ST  : WNT;
            ST:      cnt_o = (taken_i == ACT_T) ? ST  : WT;
            default: cnt_o = INIT_VAL;
        endcase
    end

endmodule

// File: rtl/branch_pht.sv
// branch_pht: 2-bit counter pattern history table with a post-reset init sweep,
// registered lookup and same-cycle read-modify-write update. Define PHT_GSHARE_EN for gshare indexing.
module branch_pht
    import bp_pkg::*;
#(
    parameter int INDEX_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    output logic               ready,
    input  logic               pred_req,
    input  logic [31:0]        pred_pc,
    output logic               pred_valid,
    output logic               pred_taken,
    output logic [INDEX_W-1:0] pred_idx,
    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_idx,
    input  logic               upd_taken
);

    localparam int DEPTH = 1 << INDEX_W;

    pht_state_e         state_q, state_d;
    logic [INDEX_W-1:0] sweep_q, sweep_d;
    logic               pred_valid_q, pred_valid_d;
    logic               pred_taken_q, pred_taken_d;
    logic [INDEX_W-1:0] pred_idx_q, pred_idx_d;

    logic [1:0]         table_q [DEPTH];

    logic [INDEX_W-1:0] lookup_idx;
    logic [1:0]         lookup_cnt;
    logic [1:0]         upd_cur;
    logic [1:0]         upd_next;
    logic               wr_en;
    logic [INDEX_W-1:0] wr_idx;
    logic [1:0]         wr_val;

`ifdef PHT_GSHARE_EN
    logic [INDEX_W-1:0] ghr_q, ghr_d;
    assign lookup_idx = pred_pc[INDEX_W+1:2] ^ ghr_q;
`else
    assign lookup_idx = pred_pc[INDEX_W+1:2];
`endif

    // PC bits outside the index field are intentionally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[31:INDEX_W+2], pred_pc[1:0]};

    assign upd_cur = table_q[upd_idx];

    counter2 u_counter2 (
        .cnt_i   (upd_cur),
        .taken_i (upd_taken),
        .cnt_o   (upd_next)
    );

    // Write-first: a same-cycle update to the looked-up entry is forwarded.
    assign lookup_cnt = (upd_valid && (upd_idx == lookup_idx)) ? upd_next : table_q[lookup_idx];

    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        wr_en        = 1'b0;
        wr_idx       = sweep_q;
        wr_val       = INIT_VAL;
        pred_valid_d = 1'b0;
        pred_taken_d = pred_taken_q;
        pred_idx_d   = pred_idx_q;
`ifdef PHT_GSHARE_EN
        ghr_d        = ghr_q;
`endif
        case (state_q)
            INIT: begin
                wr_en   = 1'b1;
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (upd_valid) begin
                    wr_en  = 1'b1;
                    wr_idx = upd_idx;
                    wr_val = upd_next;
`ifdef PHT_GSHARE_EN
                    ghr_d  = {ghr_q[INDEX_W-2:0], upd_taken};
`endif
                end
                if (pred_req) begin
                    pred_valid_d = 1'b1;
                    pred_taken_d = lookup_cnt[1];
                    pred_idx_d   = lookup_idx;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= INIT;
            sweep_q      <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_idx_q   <= '0;
`ifdef PHT_GSHARE_EN
            ghr_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_idx_q   <= pred_idx_d;
`ifdef PHT_GSHARE_EN
            ghr_q        <= ghr_d;
`endif
        end
    end

    // NOTE: the table has no reset term; the INIT sweep writes every entry, so a
    // wide reset fan-out into the array would be redundant.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            table_q[wr_idx] <= wr_val;
        end
    end

    assign ready      = (state_q == RUN);
    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign pred_idx   = pred_idx_q;

endmodule

// File: tb/tb_branch_pht.sv
// Self-checking bench for branch_pht (INDEX_W=4): directed steps then random
// traffic, compared against a behavioural table model kept in the bench.
module tb_branch_pht;

    localparam int IW = 4;
    localparam int N  = 1 << IW;

    logic          clk = 1'b0;
    logic          rst;
    logic          ready;
    logic          pred_req;
    logic [31:0]   pred_pc;
    logic          pred_valid;
    logic          pred_taken;
    logic [IW-1:0] pred_idx;
    logic          upd_valid;
    logic [IW-1:0] upd_idx;
    logic          upd_taken;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: counters held as integers 0..3, saturating arithmetic.
    int unsigned   m_pht [N];
    logic          m_ready;
    int            m_sweep;
    logic          m_valid;
    logic          m_taken;
    logic [IW-1:0] m_idx;
    logic [IW-1:0] m_ghr;

    always #5 clk = ~clk;

    branch_pht #(.INDEX_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready),
        .pred_req   (pred_req),
        .pred_pc    (pred_pc),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_idx   (pred_idx),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_taken  (upd_taken)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("ready", 32'(ready), 32'(m_ready));
        check("pred_valid", 32'(pred_valid), 32'(m_valid));
        check("pred_taken", 32'(pred_taken), 32'(m_taken));
        check("pred_idx", 32'(pred_idx), 32'(m_idx));
    endtask

    task automatic do_reset(input logic req);
        rst       = 1'b1;
        pred_req  = req;
        pred_pc   = 32'h8;
        upd_valid = 1'b0;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        m_sweep = 0;
        m_valid = 1'b0;
        m_taken = 1'b0;
        m_idx   = '0;
        m_ghr   = '0;
        check_outputs();
    endtask

    task automatic cycle(input logic req, input logic [31:0] pc, input logic uv,
                         input logic [IW-1:0] ui, input logic ut);
        logic [IW-1:0] idx;
        rst       = 1'b0;
        pred_req  = req;
        pred_pc   = pc;
        upd_valid = uv;
        upd_idx   = ui;
        upd_taken = ut;
        if (!m_ready) begin
            m_pht[m_sweep] = 1;
            m_sweep++;
            if (m_sweep == N) m_ready = 1'b1;
            m_valid = 1'b0;
        end else begin
            idx = pc[IW+1:2];
`ifdef PHT_GSHARE_EN
            idx = idx ^ m_ghr;
`endif
            if (uv) begin
                if (ut) m_pht[ui] = (m_pht[ui] == 3) ? 3 : m_pht[ui] + 1;
                else    m_pht[ui] = (m_pht[ui] == 0) ? 0 : m_pht[ui] - 1;
`ifdef PHT_GSHARE_EN
                m_ghr = {m_ghr[IW-2:0], ut};
`endif
            end
            m_valid = req;
            if (req) begin
                m_taken = (m_pht[idx] >= 2);
                m_idx   = idx;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic wait_init(input string tag);
        int cnt = 0;
        while (ready !== 1'b1 && cnt < 100) begin
            cycle(1'b0, 32'h0, 1'b0, '0, 1'b0);
            cnt++;
        end
        check(tag, 32'(cnt), 32'(N));
    endtask

    task automatic lookup_all(input string tag);
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, 32'(i << 2), 1'b0, '0, 1'b0);
            check(tag, 32'(pred_taken), 32'h0);
        end
    endtask

    initial begin
        pred_req  = 1'b0;
        pred_pc   = '0;
        upd_valid = 1'b0;
        upd_idx   = '0;
        upd_taken = 1'b0;

        // Init sweep length and all entries reading WNT.
        do_reset(1'b0);
        wait_init("init_len");
        lookup_all("init_wnt");

`ifndef PHT_GSHARE_EN
        // Saturation up, saturation down, then one taken from SNT.
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 4'd3, 1'b1);
        cycle(1'b1, 32'h0C, 1'b0, '0, 1'b0);
        check("sat_taken", 32'(pred_taken), 32'h1);
        repeat (4) cycle(1'b0, 32'h0, 1'b1, 4'd3, 1'b0);
        cycle(1'b1, 32'h0C, 1'b0, '0, 1'b0);
        check("sat_not_taken", 32'(pred_taken), 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 4'd3, 1'b1);
        cycle(1'b1, 32'h0C, 1'b0, '0, 1'b0);
        check("snt_plus_t", 32'(pred_taken), 32'h0);

        // Same-cycle hazard: entry 5 at WT, not-taken update with lookup.
        cycle(1'b0, 32'h0, 1'b1, 4'd5, 1'b1);
        cycle(1'b1, 32'h14, 1'b1, 4'd5, 1'b0);
        check("write_first", 32'(pred_taken), 32'h0);
        check("write_first_idx", 32'(pred_idx), 32'h5);
`else
        // GHR after T, T, NT is 0110, so pc 0x04 maps to 0111.
        cycle(1'b0, 32'h0, 1'b1, 4'd0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 4'd0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 4'd0, 1'b0);
        cycle(1'b1, 32'h04, 1'b0, '0, 1'b0);
        check("gshare_idx", 32'(pred_idx), 32'h7);
`endif

        // Reset mid-operation with an outstanding request.
        cycle(1'b0, 32'h0, 1'b1, 4'd2, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 4'd2, 1'b1);
        cycle(1'b1, 32'h08, 1'b0, '0, 1'b0);
        do_reset(1'b1);
        check("reset_drops_valid", 32'(pred_valid), 32'h0);
        wait_init("reinit_len");
        cycle(1'b1, 32'h08, 1'b0, '0, 1'b0);
        check("reinit_entry2", 32'(pred_taken), 32'h0);

        // Requests and updates held high throughout the sweep are ignored.
        do_reset(1'b1);
        for (int i = 0; i < 200 && !m_ready; i++) begin
            cycle(1'b1, $urandom(), 1'b1, IW'($urandom_range(0, N - 1)), 1'b1);
        end
        lookup_all("init_ignores_req");

        // Random concurrent traffic, with an occasional reset.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                cycle(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
                      IW'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
